// File: rtl/sap_microsequencer.sv
// T-state control sequencer for the SAP-style CPU: fetch T0-T2, opcode-dependent execute T3-T5,
// latched HALT with resume, and single-step gating of every live stage word.
// state | meaning
// T0-T5 | fetch / execute stage, word driven only while live
// HALT  | stopped after HLT (or unknown opcode), waits for resume_i
// HOLD  | post-reset idle, leaves on first advance
module sap_microsequencer #(
  parameter int OPCODE_W        = 4,
  parameter int STAGE_W         = 3,
  parameter bit HALT_ON_UNKNOWN = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                flag_c_i,
  input  logic                flag_z_i,
  input  logic                step_mode_i,
  input  logic                step_i,
  input  logic                resume_i,
  output logic [15:0]         cw_o,
  output logic [STAGE_W-1:0]  stage_o,
  output logic                halted_o,
  output logic                instr_done_o
);

  typedef enum logic [STAGE_W-1:0] {
    ST_T0   = STAGE_W'(0),
    ST_T1   = STAGE_W'(1),
    ST_T2   = STAGE_W'(2),
    ST_T3   = STAGE_W'(3),
    ST_T4   = STAGE_W'(4),
    ST_T5   = STAGE_W'(5),
    ST_HALT = STAGE_W'((1 << STAGE_W) - 2),
    ST_HOLD = STAGE_W'((1 << STAGE_W) - 1)
  } stage_t;

  localparam logic [15:0] CW_IDLE = 16'h0FE3;

  localparam int FLAG_LOAD = 15, PC_INC = 14, PC_EN = 13, PC_LOAD = 12;
  localparam int MAR_ADDR_N = 11, MAR_MEM_N = 10, RAM_EN_N = 9, RAM_LOAD_N = 8;
  localparam int IR_LOAD_N = 7, IR_EN_N = 6, REGA_LOAD_N = 5, REGA_EN = 4;
  localparam int ADDER_SUB = 3, REGB_EN = 2, REGB_LOAD_N = 1, OUT_LOAD_N = 0;

  localparam logic [3:0] OP_HLT = 4'h0, OP_NOP = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4, OP_OUT = 4'h5, OP_STA = 4'h6, OP_JMP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8, OP_JC  = 4'h9, OP_JZ  = 4'hA;

  stage_t      stage_q, stage_d, nxt, last;
  logic        live_q, live_d;
  logic        adv, upper_set, is_hlt, take_jmp;
  logic [3:0]  op;
  logic [15:0] word;

  assign adv       = !step_mode_i || step_i;
  assign upper_set = (opcode_i >> 4) != '0;

  always_comb begin
    op = opcode_i[3:0];
    if (upper_set || opcode_i[3:0] > OP_JZ) op = HALT_ON_UNKNOWN ? OP_HLT : OP_NOP;
  end

  assign is_hlt   = (op == OP_HLT);
  assign take_jmp = (op == OP_JMP) || (op == OP_JC && flag_c_i) || (op == OP_JZ && flag_z_i);

  always_comb begin
    word = CW_IDLE;
    case (op)
      OP_ADD, OP_SUB, OP_STA: last = ST_T5;
      OP_LDA:                 last = ST_T4;
      default:                last = ST_T3;
    endcase
    case (stage_q)
      ST_T0: begin word[PC_EN] = 1'b1; word[MAR_ADDR_N] = 1'b0; end
      ST_T1: word[PC_INC] = 1'b1;
      ST_T2: begin word[RAM_EN_N] = 1'b0; word[IR_LOAD_N] = 1'b0; end
      ST_T3: begin
        if (op == OP_ADD || op == OP_SUB || op == OP_LDA || op == OP_STA) begin
          word[IR_EN_N] = 1'b0; word[MAR_ADDR_N] = 1'b0;
        end else if (op == OP_OUT) begin
          word[REGA_EN] = 1'b1; word[OUT_LOAD_N] = 1'b0;
        end else if (op == OP_LDI) begin
          word[IR_EN_N] = 1'b0; word[REGA_LOAD_N] = 1'b0;
        end else if (take_jmp) begin
          word[IR_EN_N] = 1'b0; word[PC_LOAD] = 1'b1;
        end
      end
      ST_T4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          word[RAM_EN_N] = 1'b0; word[REGB_LOAD_N] = 1'b0;
        end else if (op == OP_LDA) begin
          word[RAM_EN_N] = 1'b0; word[REGA_LOAD_N] = 1'b0;
        end else if (op == OP_STA) begin
          word[REGA_EN] = 1'b1; word[MAR_MEM_N] = 1'b0;
        end
      end
      ST_T5: begin
        if (op == OP_ADD || op == OP_SUB) begin
          word[REGB_EN] = 1'b1; word[REGA_LOAD_N] = 1'b0; word[FLAG_LOAD] = 1'b1;
          word[ADDER_SUB] = (op == OP_SUB);
        end else if (op == OP_STA) begin
          word[RAM_LOAD_N] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Past-last guard keeps a mid-instruction opcode change from running into HALT/HOLD codes.
  always_comb begin
    case (stage_q)
      ST_T0: nxt = ST_T1;
      ST_T1: nxt = ST_T2;
      ST_T2: nxt = ST_T3;
      ST_T3, ST_T4, ST_T5: begin
        if (is_hlt)                nxt = ST_HALT;
        else if (stage_q >= last)  nxt = ST_T0;
        else                       nxt = stage_t'(stage_q + 1'b1);
      end
      default: nxt = ST_HOLD;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    live_d  = live_q;
    case (stage_q)
      ST_HOLD: if (adv) begin stage_d = ST_T0; live_d = 1'b1; end
      ST_HALT: begin
        live_d = 1'b0;
        if (resume_i) begin stage_d = ST_T0; live_d = !step_mode_i; end
      end
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5: begin
        if (live_q) begin
          stage_d = nxt;
          live_d  = !step_mode_i;
        end else if (adv) begin
          live_d = 1'b1;
        end
      end
      default: begin stage_d = ST_HOLD; live_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= ST_HOLD;
      live_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      live_q  <= live_d;
    end
  end

  assign cw_o         = live_q ? word : CW_IDLE;
  assign stage_o      = stage_q;
  assign halted_o     = (stage_q == ST_HALT);
  assign instr_done_o = live_q && !is_hlt && (stage_q == last);

endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed bench for sap_microsequencer: a default instance plus a 6-bit-opcode,
// halt-on-unknown instance sharing all other inputs.
module tb_sap_microsequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'h2;
  logic [1:0]  op_hi = 2'b00;
  logic [5:0]  opcode6;
  logic        flag_c = 1'b0, flag_z = 1'b0;
  logic        step_mode = 1'b0, step = 1'b0, resume = 1'b0;

  logic [15:0] cw, cw_h;
  logic [2:0]  stage, stage_h;
  logic        halted, halted_h, done, done_h;

  int checks = 0;
  int errors = 0;

  logic [15:0] sta_w [6] = '{16'h27E3, 16'h4FE3, 16'h0D63, 16'h07A3, 16'h0BF3, 16'h0EE3};

  assign opcode6 = {op_hi, opcode};

  sap_microsequencer dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .flag_c_i(flag_c), .flag_z_i(flag_z),
    .step_mode_i(step_mode), .step_i(step), .resume_i(resume),
    .cw_o(cw), .stage_o(stage), .halted_o(halted), .instr_done_o(done)
  );

  sap_microsequencer #(.OPCODE_W(6), .STAGE_W(3), .HALT_ON_UNKNOWN(1'b1)) dut_h (
    .clk(clk), .rst(rst), .opcode_i(opcode6), .flag_c_i(flag_c), .flag_z_i(flag_z),
    .step_mode_i(step_mode), .step_i(step), .resume_i(resume),
    .cw_o(cw_h), .stage_o(stage_h), .halted_o(halted_h), .instr_done_o(done_h)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stp(input string tag, input logic [15:0] exp_cw, input logic exp_done);
    tick();
    chk({tag, "_cw"}, cw, exp_cw);
    chk({tag, "_done"}, {15'd0, done}, {15'd0, exp_done});
  endtask

  initial begin
    tick(); tick();
    chk("rst_cw", cw, 16'h0FE3);
    chk("rst_stage", {13'd0, stage}, 16'd7);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);

    rst = 1'b0;
    stp("add_t0", 16'h27E3, 1'b0);
    stp("add_t1", 16'h4FE3, 1'b0);
    stp("add_t2", 16'h0D63, 1'b0);
    stp("add_t3", 16'h07A3, 1'b0);
    stp("add_t4", 16'h0DE1, 1'b0);
    stp("add_t5", 16'h8FC7, 1'b1);
    stp("add_next", 16'h27E3, 1'b0);

    opcode = 4'h3;
    stp("sub_t1", 16'h4FE3, 1'b0);
    stp("sub_t2", 16'h0D63, 1'b0);
    stp("sub_t3", 16'h07A3, 1'b0);
    stp("sub_t4", 16'h0DE1, 1'b0);
    stp("sub_t5", 16'h8FCF, 1'b1);
    stp("sub_next", 16'h27E3, 1'b0);

    opcode = 4'h8;
    stp("ldi_t1", 16'h4FE3, 1'b0);
    stp("ldi_t2", 16'h0D63, 1'b0);
    stp("ldi_t3", 16'h0F83, 1'b1);
    stp("ldi_next", 16'h27E3, 1'b0);

    opcode = 4'h9; flag_c = 1'b1;
    stp("jc1_t1", 16'h4FE3, 1'b0);
    stp("jc1_t2", 16'h0D63, 1'b0);
    stp("jc1_t3", 16'h1FA3, 1'b1);
    stp("jc1_next", 16'h27E3, 1'b0);
    flag_c = 1'b0; flag_z = 1'b1;
    stp("jc0_t1", 16'h4FE3, 1'b0);
    stp("jc0_t2", 16'h0D63, 1'b0);
    stp("jc0_t3", 16'h0FE3, 1'b1);
    stp("jc0_next", 16'h27E3, 1'b0);

    opcode = 4'hA; flag_c = 1'b0; flag_z = 1'b1;
    stp("jz1_t1", 16'h4FE3, 1'b0);
    stp("jz1_t2", 16'h0D63, 1'b0);
    stp("jz1_t3", 16'h1FA3, 1'b1);
    stp("jz1_next", 16'h27E3, 1'b0);
    flag_z = 1'b0; flag_c = 1'b1;
    stp("jz0_t1", 16'h4FE3, 1'b0);
    stp("jz0_t2", 16'h0D63, 1'b0);
    stp("jz0_t3", 16'h0FE3, 1'b1);
    stp("jz0_next", 16'h27E3, 1'b0);
    flag_c = 1'b0;

    opcode = 4'h5;
    stp("out_t1", 16'h4FE3, 1'b0);
    stp("out_t2", 16'h0D63, 1'b0);
    stp("out_t3", 16'h0FF2, 1'b1);
    stp("out_next", 16'h27E3, 1'b0);

    opcode = 4'h0;
    stp("hlt_t1", 16'h4FE3, 1'b0);
    stp("hlt_t2", 16'h0D63, 1'b0);
    stp("hlt_t3", 16'h0FE3, 1'b0);
    chk("hlt_t3_stage", {13'd0, stage}, 16'd3);
    for (int i = 0; i < 20; i++) begin
      step = (i == 5);
      tick();
      chk("hlt_halted", {15'd0, halted}, 16'd1);
      chk("hlt_cw", cw, 16'h0FE3);
    end
    step = 1'b0;
    chk("hlt_stage", {13'd0, stage}, 16'd6);
    opcode = 4'h1; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_cw", cw, 16'h27E3);
    chk("resume_halted", {15'd0, halted}, 16'd0);
    stp("nop_t1", 16'h4FE3, 1'b0);
    stp("nop_t2", 16'h0D63, 1'b0);
    stp("nop_t3", 16'h0FE3, 1'b1);
    stp("nop_next", 16'h27E3, 1'b0);

    opcode = 4'hF;
    stp("unkF_t1", 16'h4FE3, 1'b0);
    stp("unkF_t2", 16'h0D63, 1'b0);
    stp("unkF_t3", 16'h0FE3, 1'b1);
    chk("unkF_h_done", {15'd0, done_h}, 16'd0);
    stp("unkF_next", 16'h27E3, 1'b0);
    chk("unkF_h_halted", {15'd0, halted_h}, 16'd1);
    chk("unkF_h_cw", cw_h, 16'h0FE3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("unkF_h_resume", cw_h, 16'h27E3);
    chk("unkF_h_unhalted", {15'd0, halted_h}, 16'd0);

    rst = 1'b1;
    tick();
    op_hi = 2'b01; opcode = 4'h2; rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("upper_main_t3", cw, 16'h07A3);
    chk("upper_h_t3", cw_h, 16'h0FE3);
    chk("upper_h_done", {15'd0, done_h}, 16'd0);
    tick();
    chk("upper_main_t4", cw, 16'h0DE1);
    chk("upper_h_halted", {15'd0, halted_h}, 16'd1);

    rst = 1'b1;
    tick();
    op_hi = 2'b00; step_mode = 1'b1; opcode = 4'h6; rst = 1'b0;
    tick();
    chk("step_hold_cw", cw, 16'h0FE3);
    chk("step_hold_stage", {13'd0, stage}, 16'd7);
    for (int i = 0; i < 6; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_sta_cw", cw, sta_w[i]);
      chk("step_sta_stage", {13'd0, stage}, 16'(i));
      chk("step_sta_done", {15'd0, done}, {15'd0, i == 5});
      tick();
      chk("step_gap1", cw, 16'h0FE3);
      tick();
      chk("step_gap2", cw, 16'h0FE3);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_wrap_cw", cw, 16'h27E3);
    chk("step_wrap_stage", {13'd0, stage}, 16'd0);

    rst = 1'b1;
    tick();
    step_mode = 1'b0; opcode = 4'h4; rst = 1'b0;
    stp("lda_t0", 16'h27E3, 1'b0);
    stp("lda_t1", 16'h4FE3, 1'b0);
    stp("lda_t2", 16'h0D63, 1'b0);
    stp("lda_t3", 16'h07A3, 1'b0);
    stp("lda_t4", 16'h0DC3, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_stage", {13'd0, stage}, 16'd7);
    chk("midrst_cw", cw, 16'h0FE3);
    chk("midrst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    stp("midrst_restart", 16'h27E3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
